ccw_frame_buf: RTL

Frame buffer between the FTDI byte receiver and `hsi_master`, sitting directly upstream of the master's CCW (command/control word) port. It collects host bytes into complete frames and stores up to several frames in a byte RAM. It presents frames to `hsi_master` one byte at a time using the `ccw_*` handshake. Each frame is retained until the slave accepts it, so it can be replayed on a repeat request.

---
 rtl/hsi_pkg.sv | 12 +
 rtl/ccw_frame_buf_if.sv | 30 +++
 rtl/ccw_dpram.sv | 23 ++
 rtl/ccw_frame_buf.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hsi_pkg.sv
// Shared CCW constants and the frame buffer read-FSM encoding.
package hsi_pkg;

    localparam int CCW_MAX_LEN = 16;
    localparam int CCW_FRAMES  = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_SEND     = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

endpackage

// File: rtl/ccw_frame_buf_if.sv
// Byte-in / CCW-out bundle of the frame buffer; slave is the buffer, master its environment.
interface ccw_frame_buf_if
    import hsi_pkg::*;
#(
    parameter int FRAMES = CCW_FRAMES
);
    logic                      in_valid;
    logic [7:0]                in_d;
    logic                      in_last;
    logic                      in_rdy;
    logic                      ccw_tx_rdy;
    logic                      ccw_tx_en;
    logic [7:0]                ccw_d;
    logic                      ccw_d_rdy;
    logic                      ccw_d_sending;
    logic                      ccw_accepted;
    logic                      ccw_repeat_req;
    logic [$clog2(FRAMES):0]   frame_cnt;
    logic                      ovf;

    modport slave (
        input  in_valid, in_d, in_last, ccw_tx_en, ccw_d_sending, ccw_accepted, ccw_repeat_req,
        output in_rdy, ccw_tx_rdy, ccw_d, ccw_d_rdy, frame_cnt, ovf
    );

    modport master (
        output in_valid, in_d, in_last, ccw_tx_en, ccw_d_sending, ccw_accepted, ccw_repeat_req,
        input  in_rdy, ccw_tx_rdy, ccw_d, ccw_d_rdy, frame_cnt, ovf
    );
endinterface

// File: rtl/ccw_dpram.sv
// Simple dual-port byte RAM: one write port, one read port with a registered output.
// Read data appears one cycle after re_i; it holds while re_i is low.
module ccw_dpram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdat_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdat_o
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i)
            mem[waddr_i] <= wdat_i;
        if (re_i)
            rdat_o <= mem[raddr_i];
    end
endmodule

// File: rtl/ccw_frame_buf.sv
// Collects host bytes into frames, keeps them until the slave accepts, serves them byte-wise.
// Commit visible next cycle; 2 cycles per output byte; in_rdy drops when RAM or length FIFO fills.
module ccw_frame_buf
    import hsi_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int FRAMES  = CCW_FRAMES,
    parameter int MAX_LEN = CCW_MAX_LEN
) (
    input  logic           clk,
    input  logic           n_rst,
    ccw_frame_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int FW = $clog2(FRAMES);
    localparam int CW = FW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_base_q, rd_base_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cur_len_q, cur_len_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] len_fifo_q [FRAMES];
    logic [FW-1:0] fifo_wr_q, fifo_wr_d;
    logic [FW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]    state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          discard_q, discard_d;

    logic [PW-1:0] used;
    logic [PW-1:0] rd_off_next;
    logic          in_rdy;
    logic          in_fire;
    logic          too_long;
    logic          wr_en;
    logic          commit;
    logic          release_frm;
    logic [7:0]    rd_dat;

    assign used        = wr_ptr_q - rd_base_q;
    // While discarding, bytes are swallowed regardless of space.
    assign in_rdy      = discard_q |
                         ((used < PW'(DEPTH)) & (frame_cnt_q < CW'(FRAMES)));
    assign in_fire     = bus.in_valid & in_rdy;
    assign too_long    = !discard_q & (cur_len_q == LW'(MAX_LEN));
    assign wr_en       = in_fire & !discard_q & !too_long;
    assign commit      = wr_en & bus.in_last;
    assign release_frm = (state_q == ST_WAIT_ACK) & bus.ccw_accepted;
    assign rd_off_next = rd_ptr_q - rd_base_q + PW'(1);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        cur_len_d    = cur_len_q;
        ovf_d        = ovf_q;
        discard_d    = discard_q;
        fifo_wr_d    = fifo_wr_q;

        if (in_fire) begin
            if (discard_q) begin
                if (bus.in_last)
                    discard_d = 1'b0;
            end else if (too_long) begin
                // Drop the partial frame; an in_last on this very byte ends it immediately.
                wr_ptr_d  = commit_ptr_q;
                cur_len_d = '0;
                ovf_d     = 1'b1;
                discard_d = !bus.in_last;
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (bus.in_last) begin
                    commit_ptr_d = wr_ptr_q + PW'(1);
                    cur_len_d    = '0;
                    fifo_wr_d    = fifo_wr_q + FW'(1);
                end else begin
                    cur_len_d = cur_len_q + LW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_base_d = rd_base_q;
        len_d     = len_q;
        fifo_rd_d = fifo_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ccw_tx_en && (frame_cnt_q != '0)) begin
                    rd_ptr_d = rd_base_q;
                    len_d    = len_fifo_q[fifo_rd_q];
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.ccw_repeat_req) begin
                    rd_ptr_d = rd_base_q;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.ccw_repeat_req) begin
                    rd_ptr_d = rd_base_q;
                    state_d  = ST_IDLE;
                end else if (bus.ccw_d_sending) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = (rd_off_next == PW'(len_q)) ? ST_WAIT_ACK : ST_FETCH;
                end
            end
            default: begin
                if (bus.ccw_accepted) begin
                    rd_base_d = rd_base_q + PW'(len_q);
                    fifo_rd_d = fifo_rd_q + FW'(1);
                    state_d   = ST_IDLE;
                end else if (bus.ccw_repeat_req) begin
                    rd_ptr_d  = rd_base_q;
                    state_d   = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        case ({commit, release_frm})
            2'b10:   frame_cnt_d = frame_cnt_q + CW'(1);
            2'b01:   frame_cnt_d = frame_cnt_q - CW'(1);
            default: frame_cnt_d = frame_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_base_q    <= '0;
            rd_ptr_q     <= '0;
            cur_len_q    <= '0;
            len_q        <= '0;
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            frame_cnt_q  <= '0;
            state_q      <= ST_IDLE;
            ovf_q        <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_base_q    <= rd_base_d;
            rd_ptr_q     <= rd_ptr_d;
            cur_len_q    <= cur_len_d;
            len_q        <= len_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            frame_cnt_q  <= frame_cnt_d;
            state_q      <= state_d;
            ovf_q        <= ovf_d;
            discard_q    <= discard_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < FRAMES; i++)
                len_fifo_q[i] <= '0;
        end else if (commit) begin
            len_fifo_q[fifo_wr_q] <= cur_len_q + LW'(1);
        end
    end

    ccw_dpram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdat_i  (bus.in_d),
        .re_i    (state_q == ST_FETCH),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdat_o  (rd_dat)
    );

    assign bus.in_rdy     = in_rdy;
    assign bus.ccw_tx_rdy = (state_q == ST_IDLE) & (frame_cnt_q != '0);
    assign bus.ccw_d_rdy  = (state_q == ST_SEND);
    assign bus.ccw_d      = (state_q == ST_SEND) ? rd_dat : 8'h00;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.ovf        = ovf_q;
endmodule
